// File: rtl/risc_processor.sv
// Single-cycle 8-bit RISC core: 16-bit instructions, 4x8 register file, 256x16 ROM, 256x8 RAM, I/O port at 0xFF.
// Optional BEQ (opcode 101) enabled by defining RISC_BRANCH_EN; otherwise opcode 101 executes as a NOP.

module pc_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       pc_src_i,
  input  logic [7:0] target_i,
  output logic [7:0] pc_o
);
  logic [7:0] current_pc;
  logic [7:0] pc_d;

  assign pc_d = pc_src_i ? target_i : current_pc + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    current_pc <= 8'h00;
    else if (en_i) current_pc <= pc_d;
  end

  assign pc_o = current_pc;
endmodule

module inst_rom (
  input  logic        clk,
  input  logic        we_i,
  input  logic [7:0]  wa_i,
  input  logic [15:0] wd_i,
  input  logic [7:0]  addr_i,
  output logic [15:0] data_o
);
  logic [15:0] rom [0:255];

  // Load port is tied off in the core; contents are normally preloaded externally.
  always_ff @(posedge clk) begin
    if (we_i) rom[wa_i] <= wd_i;
  end

  assign data_o = rom[addr_i];
endmodule

module data_ram (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wd_i,
  output logic [7:0] rd_o
);
  logic [7:0] ram [0:255];

  always_ff @(posedge clk) begin
    if (we_i) ram[addr_i] <= wd_i;
  end

  assign rd_o = ram[addr_i];
endmodule

module regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [1:0] wa_i,
  input  logic [7:0] wd_i,
  input  logic [1:0] ra1_i,
  input  logic [1:0] ra2_i,
  output logic [7:0] rd1_o,
  output logic [7:0] rd2_o
);
  logic [7:0] regs [0:3];

  // R0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (we_i && wa_i != 2'd0) begin
      regs[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 2'd0) ? 8'h00 : regs[ra1_i];
  assign rd2_o = (ra2_i == 2'd0) ? 8'h00 : regs[ra2_i];
endmodule

module risc_processor (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] external_data_in,
  output logic [7:0] data_out
);
  localparam logic [2:0] OP_ALU = 3'b000, OP_LOG = 3'b001, OP_LD = 3'b010, OP_ST = 3'b011,
                         OP_JMP = 3'b100, OP_BEQ = 3'b101, OP_ADDI = 3'b110;

  logic [1:0]  sync_q;
  logic        run;
  logic [7:0]  pc;
  logic [15:0] instruction;
  logic [2:0]  opcode;
  logic        pc_src, mem_write, reg_we;
  logic [7:0]  alu_result, read_data1, read_data2, ram_rdata, wb_data;
  logic [7:0]  data_out_q, data_out_d;
  logic [1:0]  ra2;
  logic        io_hit;

  // Reset asserts asynchronously but releases through two flops; execution starts on the third edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  pc_reg pc_inst (
    .clk(clk), .rst_n(reset), .en_i(run), .pc_src_i(pc_src),
    .target_i(instruction[7:0]), .pc_o(pc)
  );

  inst_rom imem (
    .clk(clk), .we_i(1'b0), .wa_i(8'h00), .wd_i(16'h0000),
    .addr_i(pc), .data_o(instruction)
  );

  assign opcode = instruction[15:13];
  // Second read port carries rt for STORE/BEQ and rs2 for register-register ops.
  assign ra2 = (opcode == OP_ST || opcode == OP_BEQ) ? instruction[12:11] : instruction[7:6];

  regfile rf (
    .clk(clk), .rst_n(reset), .we_i(reg_we & run), .wa_i(instruction[12:11]), .wd_i(wb_data),
    .ra1_i(instruction[10:9]), .ra2_i(ra2), .rd1_o(read_data1), .rd2_o(read_data2)
  );

  data_ram dmem (
    .clk(clk), .we_i(mem_write & run), .addr_i(alu_result),
    .wd_i(read_data2), .rd_o(ram_rdata)
  );

  always_comb begin
    alu_result = 8'h00;
    wb_data    = 8'h00;
    reg_we     = 1'b0;
    mem_write  = 1'b0;
    pc_src     = 1'b0;
    io_hit     = 1'b0;
    data_out_d = data_out_q;
    case (opcode)
      OP_ALU: begin
        alu_result = instruction[8] ? read_data1 - read_data2 : read_data1 + read_data2;
        wb_data    = alu_result;
        reg_we     = 1'b1;
      end
      OP_LOG: begin
        alu_result = instruction[8] ? (read_data1 | read_data2) : (read_data1 & read_data2);
        wb_data    = alu_result;
        reg_we     = 1'b1;
      end
      OP_LD: begin
        alu_result = read_data1 + instruction[7:0];
        io_hit     = (alu_result == 8'hFF);
        wb_data    = io_hit ? external_data_in : ram_rdata;
        reg_we     = 1'b1;
      end
      OP_ST: begin
        alu_result = read_data1 + instruction[7:0];
        io_hit     = (alu_result == 8'hFF);
        mem_write  = !io_hit;
        if (io_hit) data_out_d = read_data2;
      end
      OP_JMP: begin
        alu_result = instruction[7:0];
        pc_src     = 1'b1;
      end
`ifdef RISC_BRANCH_EN
      OP_BEQ: begin
        alu_result = instruction[7:0];
        pc_src     = (read_data2 == read_data1);
      end
`endif
      OP_ADDI: begin
        alu_result = read_data1 + instruction[7:0];
        wb_data    = alu_result;
        reg_we     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   data_out_q <= 8'h00;
    else if (run) data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
endmodule

// File: tb/tb_risc_processor.sv
// Directed bench for risc_processor: reset/restart sequence, each opcode, I/O port, R0, wrap and BEQ cases.
module tb_risc_processor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] external_data_in = 8'h00;
  logic [7:0] data_out;
  int checks = 0;
  int errors = 0;

  risc_processor dut (
    .clk(clk), .reset(reset), .external_data_in(external_data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dut.imem.rom[i] = 16'hE000;
    dut.imem.rom[8'h00] = 16'h4810;  // LOAD R1,[R0+10]
    dut.imem.rom[8'h01] = 16'h1200;  // ADD  R2,R1,R0
    dut.imem.rom[8'h02] = 16'h7020;  // STORE R2,[R0+20]
    dut.imem.rom[8'h03] = 16'h8005;  // JUMP 05
    dut.imem.rom[8'h04] = 16'hD8EE;  // ADDI R3,R0,EE (skipped)
    dut.imem.rom[8'h05] = 16'h48FF;  // LOAD R1,[R0+FF] -> input port
    dut.imem.rom[8'h06] = 16'h1B80;  // SUB  R3,R1,R2
    dut.imem.rom[8'h07] = 16'hC85A;  // ADDI R1,R0,5A
    dut.imem.rom[8'h08] = 16'h68FF;  // STORE R1,[R0+FF] -> output port
    dut.imem.rom[8'h09] = 16'hC077;  // ADDI R0,R0,77 (discarded)
    dut.imem.rom[8'h0A] = 16'h33C0;  // OR   R2,R1,R3
    dut.imem.rom[8'h0B] = 16'h3AC0;  // AND  R3,R1,R3
    dut.imem.rom[8'h0C] = 16'hD4B0;  // ADDI R2,R2,B0 (wraps)
    dut.imem.rom[8'h0D] = 16'hA014;  // BEQ  R0,R0,14
    dut.imem.rom[8'h0E] = 16'hA814;  // BEQ  R1,R0,14 (not taken)
    dut.imem.rom[8'h14] = 16'hA814;
    dut.imem.rom[8'h0F] = 16'h80FF;  // JUMP FF
    dut.imem.rom[8'h15] = 16'h80FF;
    for (int i = 0; i < 256; i++) dut.dmem.ram[i] = 8'h00;
    dut.dmem.ram[8'h10] = 8'hA5;
    dut.dmem.ram[8'hFF] = 8'h33;

    #12;
    chk("rst_pc", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    chk("rst_r0", {8'h0, dut.rf.regs[0]}, 16'h00);
    chk("rst_r1", {8'h0, dut.rf.regs[1]}, 16'h00);
    chk("rst_r2", {8'h0, dut.rf.regs[2]}, 16'h00);
    chk("rst_r3", {8'h0, dut.rf.regs[3]}, 16'h00);
    chk("rst_dout", {8'h0, data_out}, 16'h00);

    reset = 1'b1;
    step(); chk("sync1_pc", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    step(); chk("sync2_pc", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    step(); chk("ld_pc", {8'h0, dut.pc_inst.current_pc}, 16'h01);
    chk("ld_r1", {8'h0, dut.rf.regs[1]}, 16'hA5);
    step(); chk("add_r2", {8'h0, dut.rf.regs[2]}, 16'hA5);
    chk("st_mem_write", {15'h0, dut.mem_write}, 16'h1);
    chk("st_alu_result", {8'h0, dut.alu_result}, 16'h20);
    chk("st_read_data2", {8'h0, dut.read_data2}, 16'hA5);
    step(); chk("st_ram20", {8'h0, dut.dmem.ram[8'h20]}, 16'hA5);
    chk("jmp_pc_src", {15'h0, dut.pc_src}, 16'h1);
    step(); chk("jmp_pc", {8'h0, dut.pc_inst.current_pc}, 16'h05);
    chk("skip_r3", {8'h0, dut.rf.regs[3]}, 16'h00);
    external_data_in = 8'hF0;
    step(); chk("ldio_r1", {8'h0, dut.rf.regs[1]}, 16'hF0);
    step(); chk("sub_r3", {8'h0, dut.rf.regs[3]}, 16'h4B);
    step(); chk("addi_r1", {8'h0, dut.rf.regs[1]}, 16'h5A);
    chk("stio_mem_write", {15'h0, dut.mem_write}, 16'h0);
    step(); chk("stio_dout", {8'h0, data_out}, 16'h5A);
    chk("stio_ramff", {8'h0, dut.dmem.ram[8'hFF]}, 16'h33);
    step(); chk("r0_zero", {8'h0, dut.rf.regs[0]}, 16'h00);
    step(); chk("or_r2", {8'h0, dut.rf.regs[2]}, 16'h5B);
    step(); chk("and_r3", {8'h0, dut.rf.regs[3]}, 16'h4A);
    step(); chk("addi_wrap_r2", {8'h0, dut.rf.regs[2]}, 16'h0B);
    chk("beq_pc", {8'h0, dut.pc_inst.current_pc}, 16'h0D);
`ifdef RISC_BRANCH_EN
    chk("beq_taken_src", {15'h0, dut.pc_src}, 16'h1);
    step(); chk("beq_taken_pc", {8'h0, dut.pc_inst.current_pc}, 16'h14);
    chk("beq_nt_src", {15'h0, dut.pc_src}, 16'h0);
    step(); chk("beq_nt_pc", {8'h0, dut.pc_inst.current_pc}, 16'h15);
`else
    chk("beq_nop_src", {15'h0, dut.pc_src}, 16'h0);
    step(); chk("beq_nop_pc", {8'h0, dut.pc_inst.current_pc}, 16'h0E);
    chk("beq_nt_src", {15'h0, dut.pc_src}, 16'h0);
    step(); chk("beq_nt_pc", {8'h0, dut.pc_inst.current_pc}, 16'h0F);
`endif
    step(); chk("jmp_ff_pc", {8'h0, dut.pc_inst.current_pc}, 16'hFF);
    step(); chk("pc_wrap", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    step(); chk("rerun_pc", {8'h0, dut.pc_inst.current_pc}, 16'h01);

    reset = 1'b0;
    #1;
    chk("mid_rst_pc", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    chk("mid_rst_dout", {8'h0, data_out}, 16'h00);
    chk("mid_rst_r1", {8'h0, dut.rf.regs[1]}, 16'h00);
    chk("mid_rst_ram20", {8'h0, dut.dmem.ram[8'h20]}, 16'hA5);
    step();
    reset = 1'b1;
    step(); chk("re_sync1_pc", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    step(); chk("re_sync2_pc", {8'h0, dut.pc_inst.current_pc}, 16'h00);
    step(); chk("re_exec_pc", {8'h0, dut.pc_inst.current_pc}, 16'h01);
    chk("re_exec_r1", {8'h0, dut.rf.regs[1]}, 16'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
